// File: rtl/assoc_cache.sv
// assoc_cache: N-way set-associative, write-back, write-allocate cache with
// true-LRU replacement and a request/acknowledge backing-memory port.
// One data word per line; hit/miss statistics with saturating counters.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   req, we, addr, wdata     CPU request (sampled only while busy=0)
//   busy, done, hit, rdata   CPU status / completion / read result
//   mem_req, mem_we,         backing-memory transaction (write-back or refill)
//   mem_addr, mem_wdata
//   mem_ack, mem_rdata       memory completion and refill data
//   hit_cnt, miss_cnt        saturating statistics
module assoc_cache #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 16,
   parameter int unsigned SETS   = 4,
   parameter int unsigned WAYS   = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              busy,
   output logic              done,
   output logic              hit,
   output logic [DATA_W-1:0] rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [15:0]       hit_cnt,
   output logic [15:0]       miss_cnt
);

   localparam int unsigned INDEX_W = $clog2(SETS);
   localparam int unsigned TAG_W   = ADDR_W - INDEX_W;
   localparam int unsigned AGE_W   = $clog2(WAYS);
   localparam int unsigned CNT_W   = 16;

   typedef enum logic [1:0] {S_IDLE, S_TAG, S_WB, S_FILL} state_t;

   state_t state_q, state_d;

   // Latched request
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [AGE_W-1:0]  victim_q;

   // Line storage
   logic              valid_q [SETS][WAYS];
   logic              dirty_q [SETS][WAYS];
   logic [AGE_W-1:0]  age_q   [SETS][WAYS];
   logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
   logic [DATA_W-1:0] data_q  [SETS][WAYS];

   // Registered outputs
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              hit_q, hit_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
   logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;

   // Lookup results
   logic [INDEX_W-1:0] idx_c;
   logic [TAG_W-1:0]   tag_c;
   logic               hit_c;
   logic [AGE_W-1:0]   hit_way_c;
   logic               inv_found_c;
   logic [AGE_W-1:0]   inv_way_c;
   logic [AGE_W-1:0]   lru_way_c;
   logic [AGE_W-1:0]   victim_c;
   logic [AGE_W-1:0]   sel_way_c;
   logic               victim_dirty_c;
   logic               touch_en_c;
   logic [AGE_W-1:0]   touch_way_c;
   logic               fill_en_c;

   assign idx_c = addr_q[INDEX_W-1:0];
   assign tag_c = addr_q[ADDR_W-1:INDEX_W];

   // Tag compare, lowest invalid way, and oldest way of the addressed set
   always_comb begin
      hit_c       = 1'b0;
      hit_way_c   = '0;
      inv_found_c = 1'b0;
      inv_way_c   = '0;
      lru_way_c   = '0;
      for (int unsigned w = 0; w < WAYS; w++) begin
         if (valid_q[idx_c][w] && (tag_q[idx_c][w] == tag_c)) begin
            hit_c     = 1'b1;
            hit_way_c = AGE_W'(w);
         end
         if (!valid_q[idx_c][w] && !inv_found_c) begin
            inv_found_c = 1'b1;
            inv_way_c   = AGE_W'(w);
         end
         if (age_q[idx_c][w] == AGE_W'(WAYS - 1)) begin
            lru_way_c = AGE_W'(w);
         end
      end
      victim_c = inv_found_c ? inv_way_c : lru_way_c;
   end

   // The victim is decided in TAG and held for WB/FILL
   assign sel_way_c      = (state_q == S_TAG) ? victim_c : victim_q;
   assign victim_dirty_c = valid_q[idx_c][victim_c] && dirty_q[idx_c][victim_c];
   assign touch_en_c     = ((state_q == S_TAG) && hit_c) || fill_en_c;
   assign touch_way_c    = (state_q == S_TAG) ? hit_way_c : victim_q;
   assign fill_en_c      = (state_q == S_FILL) && mem_ack;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (req) state_d = S_TAG;
         S_TAG: begin
            if (hit_c)               state_d = S_IDLE;
            else if (victim_dirty_c) state_d = S_WB;
            else                     state_d = S_FILL;
         end
         S_WB:   if (mem_ack) state_d = S_FILL;
         S_FILL: if (mem_ack) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output logic: next values of the registered outputs
   always_comb begin
      done_d      = 1'b0;
      hit_d       = hit_q;
      rdata_d     = rdata_q;
      hit_cnt_d   = hit_cnt_q;
      miss_cnt_d  = miss_cnt_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      busy_d      = (state_d != S_IDLE);
      mem_req_d   = (state_d == S_WB) || (state_d == S_FILL);
      mem_we_d    = (state_d == S_WB);

      case (state_q)
         S_TAG: begin
            if (hit_c) begin
               done_d  = 1'b1;
               hit_d   = 1'b1;
               rdata_d = we_q ? wdata_q : data_q[idx_c][hit_way_c];
               if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_W'(1);
            end else begin
               if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_W'(1);
            end
         end
         S_FILL: begin
            if (mem_ack) begin
               done_d  = 1'b1;
               hit_d   = 1'b0;
               rdata_d = we_q ? wdata_q : mem_rdata;
            end
         end
         default: ;
      endcase

      if (state_d == S_WB) begin
         mem_addr_d  = {tag_q[idx_c][sel_way_c], idx_c};
         mem_wdata_d = data_q[idx_c][sel_way_c];
      end else if (state_d == S_FILL) begin
         mem_addr_d  = addr_q;
      end
   end

   // Output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         hit_q       <= 1'b0;
         rdata_q     <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         hit_cnt_q   <= '0;
         miss_cnt_q  <= '0;
      end else begin
         busy_q      <= busy_d;
         done_q      <= done_d;
         hit_q       <= hit_d;
         rdata_q     <= rdata_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         hit_cnt_q   <= hit_cnt_d;
         miss_cnt_q  <= miss_cnt_d;
      end
   end

   // Request latch, victim, valid/dirty and LRU ages
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         victim_q <= '0;
         for (int unsigned s = 0; s < SETS; s++) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
               valid_q[s][w] <= 1'b0;
               dirty_q[s][w] <= 1'b0;
               age_q[s][w]   <= AGE_W'(w);
            end
         end
      end else begin
         if ((state_q == S_IDLE) && req) begin
            we_q    <= we;
            addr_q  <= addr;
            wdata_q <= wdata;
         end
         if (state_q == S_TAG) victim_q <= victim_c;

         if ((state_q == S_TAG) && hit_c && we_q) dirty_q[idx_c][hit_way_c] <= 1'b1;
         if (fill_en_c) begin
            valid_q[idx_c][victim_q] <= 1'b1;
            dirty_q[idx_c][victim_q] <= we_q;
         end

         // Ways younger than the touched one age by one; touched way becomes newest
         if (touch_en_c) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
               if (AGE_W'(w) == touch_way_c)
                  age_q[idx_c][w] <= '0;
               else if (age_q[idx_c][w] < age_q[idx_c][touch_way_c])
                  age_q[idx_c][w] <= age_q[idx_c][w] + AGE_W'(1);
            end
         end
      end
   end

   // Tag and data arrays need no reset: valid bits gate every use
   always_ff @(posedge clk) begin
      if ((state_q == S_TAG) && hit_c && we_q) data_q[idx_c][hit_way_c] <= wdata_q;
      if (fill_en_c) begin
         tag_q[idx_c][victim_q]  <= tag_c;
         data_q[idx_c][victim_q] <= we_q ? wdata_q : mem_rdata;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign hit       = hit_q;
   assign rdata     = rdata_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign hit_cnt   = hit_cnt_q;
   assign miss_cnt  = miss_cnt_q;

endmodule

// File: tb/tb_assoc_cache.sv
// Directed bench for assoc_cache (SETS=4, WAYS=2, 16-bit address/data).
module tb_assoc_cache;

   logic        clk = 1'b0;
   logic        rst;
   logic        req, we;
   logic [15:0] addr, wdata;
   logic        busy, done, hit;
   logic [15:0] rdata;
   logic        mem_req, mem_we;
   logic [15:0] mem_addr, mem_wdata;
   logic        mem_ack;
   logic [15:0] mem_rdata;
   logic [15:0] hit_cnt, miss_cnt;

   int errors = 0;
   int checks = 0;

   assoc_cache #(.ADDR_W(16), .DATA_W(16), .SETS(4), .WAYS(2)) dut (
      .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .busy(busy), .done(done), .hit(hit), .rdata(rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic issue_now(input logic w, input logic [15:0] a, input logic [15:0] d);
      req = 1'b1; we = w; addr = a; wdata = d;
      @(negedge clk);
      req = 1'b0;
   endtask

   task automatic issue(input logic w, input logic [15:0] a, input logic [15:0] d);
      @(negedge clk);
      issue_now(w, a, d);
   endtask

   task automatic check_done(input string tag, input logic eh, input logic [15:0] erd);
      chk({tag, " done"}, 16'(done), 16'h1);
      chk({tag, " hit"}, 16'(hit), 16'(eh));
      chk({tag, " rdata"}, rdata, erd);
      chk({tag, " busy"}, 16'(busy), 16'h0);
   endtask

   // Wait for a memory request, check it, hold it for 'delay' cycles, then ack
   task automatic serve(input string tag, input logic ewe, input logic [15:0] eaddr,
                        input logic [15:0] ewd, input logic [15:0] rd,
                        input int delay, input bit poke);
      int n = 0;
      while (!mem_req && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({tag, " mem_req"}, 16'(mem_req), 16'h1);
      if (!mem_req) return;
      chk({tag, " mem_we"}, 16'(mem_we), 16'(ewe));
      chk({tag, " mem_addr"}, mem_addr, eaddr);
      if (ewe) chk({tag, " mem_wdata"}, mem_wdata, ewd);
      for (int i = 0; i < delay; i++) begin
         if (poke && i == 1) begin
            req = 1'b1; we = 1'b1; addr = 16'h0030; wdata = 16'hDEAD;
         end
         @(negedge clk);
         req = 1'b0;
         chk({tag, " hold mem_req"}, 16'(mem_req), 16'h1);
         chk({tag, " hold mem_we"}, 16'(mem_we), 16'(ewe));
         chk({tag, " hold mem_addr"}, mem_addr, eaddr);
         if (ewe) chk({tag, " hold mem_wdata"}, mem_wdata, ewd);
         chk({tag, " hold done"}, 16'(done), 16'h0);
      end
      mem_ack = 1'b1; mem_rdata = rd;
      @(negedge clk);
      mem_ack = 1'b0; mem_rdata = 16'h0;
   endtask

   initial begin
      rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
      mem_ack = 1'b0; mem_rdata = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Reset state
      chk("rst busy", 16'(busy), 16'h0);
      chk("rst done", 16'(done), 16'h0);
      chk("rst mem_req", 16'(mem_req), 16'h0);
      chk("rst rdata", rdata, 16'h0);
      chk("rst hit_cnt", hit_cnt, 16'h0);
      chk("rst miss_cnt", miss_cnt, 16'h0);

      // Cold read miss of 0x0004, ack after 2 wait cycles
      issue(1'b0, 16'h0004, 16'h0);
      chk("cold busy", 16'(busy), 16'h1);
      chk("cold tag no mem_req", 16'(mem_req), 16'h0);
      serve("cold fill", 1'b0, 16'h0004, 16'h0, 16'hBEEF, 2, 1'b0);
      check_done("cold", 1'b0, 16'hBEEF);
      chk("cold mem_req low", 16'(mem_req), 16'h0);
      chk("cold miss_cnt", miss_cnt, 16'd1);
      @(negedge clk);
      chk("cold done pulse", 16'(done), 16'h0);

      // Re-read hits at E0+1
      issue(1'b0, 16'h0004, 16'h0);
      @(negedge clk);
      chk("reread mem_req", 16'(mem_req), 16'h0);
      check_done("reread", 1'b1, 16'hBEEF);
      chk("reread hit_cnt", hit_cnt, 16'd1);

      // Write hit, then back-to-back read in the done cycle
      issue(1'b1, 16'h0004, 16'h1234);
      @(negedge clk);
      chk("wrhit mem_req", 16'(mem_req), 16'h0);
      check_done("wrhit", 1'b1, 16'h1234);
      issue_now(1'b0, 16'h0004, 16'h0);
      chk("b2b busy", 16'(busy), 16'h1);
      @(negedge clk);
      check_done("b2b read", 1'b1, 16'h1234);
      chk("b2b hit_cnt", hit_cnt, 16'd3);

      // Fill 0x0008 into the free way, touch it, then 0x000C evicts dirty 0x0004
      issue(1'b0, 16'h0008, 16'h0);
      serve("fill8", 1'b0, 16'h0008, 16'h0, 16'hAAAA, 1, 1'b0);
      check_done("fill8", 1'b0, 16'hAAAA);
      issue(1'b0, 16'h0008, 16'h0);
      @(negedge clk);
      check_done("hit8", 1'b1, 16'hAAAA);
      issue(1'b0, 16'h000C, 16'h0);
      serve("wb4", 1'b1, 16'h0004, 16'h1234, 16'h0, 0, 1'b0);
      chk("wb->fill mem_req", 16'(mem_req), 16'h1);
      chk("wb->fill done", 16'(done), 16'h0);
      serve("fillC", 1'b0, 16'h000C, 16'h0, 16'hCCCC, 0, 1'b0);
      check_done("fillC", 1'b0, 16'hCCCC);
      issue(1'b0, 16'h0008, 16'h0);
      @(negedge clk);
      check_done("hit8 again", 1'b1, 16'hAAAA);
      chk("evict hit_cnt", hit_cnt, 16'd5);
      chk("evict miss_cnt", miss_cnt, 16'd3);

      // Write miss: refill read, then written data kept (refill data ignored)
      issue(1'b1, 16'h0010, 16'h5555);
      serve("wrmiss fill", 1'b0, 16'h0010, 16'h0, 16'h9999, 0, 1'b0);
      check_done("wrmiss", 1'b0, 16'h5555);
      chk("wrmiss miss_cnt", miss_cnt, 16'd4);

      // 0x0018 takes the older way, 0x001C then evicts dirty 0x0010 with a stall
      issue(1'b0, 16'h0018, 16'h0);
      serve("fill18", 1'b0, 16'h0018, 16'h0, 16'h1818, 0, 1'b0);
      check_done("fill18", 1'b0, 16'h1818);
      issue(1'b0, 16'h001C, 16'h0);
      serve("stall wb10", 1'b1, 16'h0010, 16'h5555, 16'h0, 5, 1'b1);
      serve("fill1C", 1'b0, 16'h001C, 16'h0, 16'h1C1C, 0, 1'b0);
      check_done("fill1C", 1'b0, 16'h1C1C);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("post-stall done", 16'(done), 16'h0);
         chk("post-stall busy", 16'(busy), 16'h0);
         chk("post-stall mem_req", 16'(mem_req), 16'h0);
      end
      chk("stall miss_cnt", miss_cnt, 16'd6);
      chk("stall hit_cnt", hit_cnt, 16'd5);

      // Reset during FILL before ack
      issue(1'b0, 16'h0020, 16'h0);
      for (int i = 0; i < 20 && !mem_req; i++) @(negedge clk);
      chk("midrst mem_req before", 16'(mem_req), 16'h1);
      chk("midrst mem_addr", mem_addr, 16'h0020);
      #2 rst = 1'b1;
      #1;
      chk("midrst mem_req", 16'(mem_req), 16'h0);
      chk("midrst busy", 16'(busy), 16'h0);
      chk("midrst hit_cnt", hit_cnt, 16'h0);
      chk("midrst miss_cnt", miss_cnt, 16'h0);
      @(negedge clk);
      rst = 1'b0;
      issue(1'b0, 16'h0020, 16'h0);
      serve("refill20", 1'b0, 16'h0020, 16'h0, 16'h2020, 1, 1'b0);
      check_done("refill20", 1'b0, 16'h2020);
      chk("refill miss_cnt", miss_cnt, 16'd1);
      chk("refill hit_cnt", hit_cnt, 16'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
